// File: rtl/gate_bist_pkg.sv
// -----------------------------------------------------------------------------
// gate_bist_pkg
// Shared definitions for the gate BIST controller:
//   - bist_state_e : controller state encoding (IDLE, RUN, DONE)
//   - default widths and Galois feedback polynomials
//   - galois_step() : one Galois shift step with parallel data injection,
//                     shared by the pattern LFSR, the MISR and the pass compare
// -----------------------------------------------------------------------------
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bist_state_e;

    localparam int DEF_IN_W  = 14;
    localparam int DEF_OUT_W = 10;
    localparam int DEF_CNT_W = 16;

    // x^14 + x^5 + x^3 + x + 1 (x^14 term implicit)
    localparam logic [DEF_IN_W-1:0]  DEF_LFSR_POLY = 14'h002B;
    // x^10 + x^3 + 1 (x^10 term implicit)
    localparam logic [DEF_OUT_W-1:0] DEF_MISR_POLY = 10'h009;

    // Widest register the step helper supports.
    localparam int GB_MAX_W = 32;

    // One Galois step of a `width`-bit register held in the low bits of cur:
    //   next[i] = cur[i-1] (0 for i=0) ^ (poly[i] & cur[width-1]) ^ data[i]
    // Bits at and above `width` are forced to zero.
    function automatic logic [GB_MAX_W-1:0] galois_step(
        input logic [GB_MAX_W-1:0] cur,
        input logic [GB_MAX_W-1:0] poly,
        input logic [GB_MAX_W-1:0] data,
        input int                  width
    );
        logic [GB_MAX_W-1:0] mask;
        logic [GB_MAX_W-1:0] shifted;
        mask    = (GB_MAX_W'(1) << width) - GB_MAX_W'(1);
        shifted = (cur << 1) & mask;
        if (((cur >> (width - 1)) & GB_MAX_W'(1)) != '0) begin
            shifted = shifted ^ poly;
        end
        return (shifted ^ data) & mask;
    endfunction

endpackage

// File: rtl/gate_bist_lfsr.sv
// -----------------------------------------------------------------------------
// gate_bist_lfsr
// Galois shift register with synchronous load and a parallel data input.
// With data_i tied to zero it is a pattern LFSR; fed with a circuit response
// it is a MISR.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   async active-low reset, clears the register
//   load_i      in   load load_val_i this cycle (wins over step_i)
//   load_val_i  in   WIDTH  value to load
//   step_i      in   advance one Galois step, XOR-ing in data_i
//   data_i      in   WIDTH  parallel data absorbed on a step
//   state_o     out  WIDTH  current register contents
// -----------------------------------------------------------------------------
module gate_bist_lfsr
    import gate_bist_pkg::*;
#(
    parameter int               WIDTH = DEF_IN_W,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_LFSR_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] step_val;

    assign step_val = WIDTH'(galois_step(GB_MAX_W'(state_q), GB_MAX_W'(POLY),
                                         GB_MAX_W'(data_i), WIDTH));

    // NOTE: state_d gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = load_val_i;
        end else if (step_i) begin
            state_d = step_val;
        end
    end

    // NOTE: non-blocking assignment for all clocked state so every flop samples
    // the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// gate_bist_ctrl
// Logic BIST controller for a combinational gate model. A run drives pat_count
// pseudo-random patterns from a Galois LFSR into the model, compacts each
// response into a MISR, and on completion compares the signature to golden.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   async active-low reset
//   start        in   begin a run (accepted in IDLE or DONE only)
//   abort        in   terminate a run (accepted in RUN only)
//   pat_count    in   CNT_W  number of patterns to apply
//   seed         in   IN_W   LFSR start value (0 is replaced by 1)
//   golden       in   OUT_W  expected signature
//   resp_in      in   OUT_W  combinational response of the model to pattern_out
//   pattern_out  out  IN_W   registered stimulus to the model
//   busy         out  high in RUN
//   done         out  high in DONE
//   pass         out  signature == golden, valid while done is high
//   signature    out  OUT_W  MISR contents
// -----------------------------------------------------------------------------
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int               IN_W      = DEF_IN_W,
    parameter int               OUT_W     = DEF_OUT_W,
    parameter int               CNT_W     = DEF_CNT_W,
    parameter logic [IN_W-1:0]  LFSR_POLY = IN_W'(DEF_LFSR_POLY),
    parameter logic [OUT_W-1:0] MISR_POLY = OUT_W'(DEF_MISR_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] pat_count,
    input  logic [IN_W-1:0]  seed,
    input  logic [OUT_W-1:0] golden,
    input  logic [OUT_W-1:0] resp_in,
    output logic [IN_W-1:0]  pattern_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);

    bist_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;

    logic             lfsr_load, lfsr_step;
    logic             misr_load, misr_step;
    logic [IN_W-1:0]  lfsr_seed;
    logic [OUT_W-1:0] misr_absorb;

    // An all-zero state would lock the LFSR, so a zero seed starts at 1.
    assign lfsr_seed = (seed == '0) ? IN_W'(1) : seed;

    // Value the MISR takes if it absorbs resp_in this cycle; used to register
    // pass on the same edge that the final absorb lands.
    assign misr_absorb = OUT_W'(galois_step(GB_MAX_W'(signature), GB_MAX_W'(MISR_POLY),
                                            GB_MAX_W'(resp_in), OUT_W));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        misr_load = 1'b0;
        misr_step = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    misr_load = 1'b1;
                    if (pat_count != '0) begin
                        lfsr_load = 1'b1;
                        cnt_d     = pat_count;
                        pass_d    = 1'b0;
                        state_d   = ST_RUN;
                    end else begin
                        // Empty run: signature stays cleared, so it matches
                        // only a zero golden.
                        pass_d  = (golden == '0);
                        state_d = ST_DONE;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Drop this cycle's response; the MISR keeps the partial value.
                    state_d = ST_IDLE;
                end else begin
                    lfsr_step = 1'b1;
                    misr_step = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        pass_d  = (misr_absorb == golden);
                        state_d = ST_DONE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    gate_bist_lfsr #(
        .WIDTH (IN_W),
        .POLY  (LFSR_POLY)
    ) u_pattern_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (lfsr_load),
        .load_val_i (lfsr_seed),
        .step_i     (lfsr_step),
        .data_i     ('0),
        .state_o    (pattern_out)
    );

    gate_bist_lfsr #(
        .WIDTH (OUT_W),
        .POLY  (MISR_POLY)
    ) u_misr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (misr_load),
        .load_val_i ('0),
        .step_i     (misr_step),
        .data_i     (resp_in),
        .state_o    (signature)
    );

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign pass = pass_q;

endmodule

// File: doc/gate_bist_ctrl.md
GATE_BIST_CTRL -- requirements
Module: gate_bist_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 14, pattern width driven into the gate model under test.
REQ-002 SHALL have parameter OUT_W, default 10, response width from the gate model.
REQ-003 SHALL have parameter CNT_W, default 16, width of the pattern counter.
REQ-004 SHALL have parameter LFSR_POLY [IN_W], default 14'h002B (x^14+x^5+x^3+x+1), Galois feedback mask with the x^IN_W term implicit.
REQ-005 SHALL have parameter MISR_POLY [OUT_W], default 10'h009 (x^10+x^3+1), Galois feedback mask.
REQ-006 SHALL use one clock, clk; reset rst_n is asynchronous, active-low.
REQ-007 Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
start  in  1  begin a run; sampled only in IDLE or DONE
abort  in  1  terminate a run; sampled only in RUN
pat_count  in  CNT_W  number of patterns to apply
seed  in  IN_W  LFSR start value
golden  in  OUT_W  expected signature
resp_in  in  OUT_W  combinational response of the gate model to pattern_out
pattern_out  out  IN_W  registered stimulus to the gate model
busy  out  1  high in RUN
done  out  1  high in DONE
pass  out  1  valid while done=1: signature == golden
signature  out  OUT_W  MISR contents

Function
REQ-008 States SHALL be IDLE, RUN, DONE.
REQ-009 IDLE/DONE with start=1 and pat_count!=0 SHALL load pattern_out<=seed (14'h0001-equivalent value 1 if seed==0), misr<=0, cnt<=pat_count, and go to RUN.
REQ-010 IDLE/DONE with start=1 and pat_count==0 SHALL clear misr, go to DONE; pass SHALL reflect golden==0.
REQ-011 Each RUN cycle SHALL absorb resp_in: misr_next[i] = misr[i-1] (0 for i=0) ^ (MISR_POLY[i] & misr[OUT_W-1]) ^ resp_in[i].
REQ-012 Each RUN cycle SHALL advance the LFSR: lfsr_next[i] = lfsr[i-1] (0 for i=0) ^ (LFSR_POLY[i] & lfsr[IN_W-1]).
REQ-013 Each RUN cycle SHALL decrement cnt; the cycle with cnt==1 SHALL be the last absorb and transition to DONE.
REQ-014 Exactly pat_count patterns SHALL be applied and absorbed; run latency start-to-done = pat_count+1 cycles.
REQ-015 pass SHALL be registered on entry to DONE and held; done SHALL stay high until the next start.
REQ-016 abort in RUN SHALL return to IDLE without absorbing that cycle's response; signature SHALL hold the partial value; done stays 0.
REQ-017 start during RUN SHALL be ignored; abort and start outside their states SHALL be ignored.
REQ-018 Arithmetic on cnt SHALL be unsigned CNT_W; no wrap below 1 is reachable.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, pattern_out=0, signature=0, cnt=0, busy=0, done=0, pass=0.
REQ-020 Reset mid-RUN SHALL discard the run; after release the block SHALL wait in IDLE for start.

Structure
REQ-021 Shared package gate_bist_pkg SHALL hold the state enum and default polynomial constants.
REQ-022 One sub-module, gate_bist_lfsr (parametrised width/poly, load/step), SHALL be instantiated for both pattern LFSR and MISR (MISR using its parallel data input).

Verification
REQ-023 seed=14'h2000, pat_count=2 -> pattern_out 14'h2000 in cycle 1, 14'h002B in cycle 2; done after 3 cycles.
REQ-024 pat_count=1, resp_in=10'h3FF -> signature 10'h3FF, golden=10'h3FF gives pass=1.
REQ-025 pat_count=2, resp_in 10'h200 then 10'h000 -> signature 10'h009; golden=10'h008 gives pass=0.
REQ-026 pat_count=0, start -> DONE next cycle, signature 0, pass=(golden==0).
REQ-027 pat_count=5, abort in third RUN cycle -> IDLE, busy=0, done=0, signature = two-pattern partial value.
REQ-028 seed=0, rst_n pulsed low mid-RUN -> all outputs 0 immediately; restart loads pattern_out=14'h0001.
